// File: rtl/divide8_signed_seq.sv
// rtl/divide8_signed_seq.sv - 16/8 signed restoring divider, fixed 18-cycle start/done handshake
// Quotient truncates toward zero and saturates; remainder follows the dividend sign.
module divide8_signed_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor_b,
  output logic [7:0]  quotient,
  output logic [7:0]  remainder,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t      r_state;
  logic [15:0] r_dvd_sh;
  logic [7:0]  r_dvs_mag;
  logic [7:0]  r_rem;
  logic [15:0] r_quo;
  logic [4:0]  r_cnt;
  logic        r_sign_q;
  logic        r_sign_r;
  logic        r_zero;
  logic [7:0]  r_dvd_lo;

  // A 16-bit unsigned magnitude already holds 32768, the only value needing a 17th signed bit.
  logic [15:0] w_dvd_mag;
  logic [7:0]  w_dvs_mag;
  logic [8:0]  w_trial;
  logic        w_ge;
  logic [7:0]  w_diff;
  logic        w_ovf;
  logic [7:0]  w_q_neg;
  logic [7:0]  w_rem_neg;

  assign w_dvd_mag = dividend[15]  ? (~dividend + 16'd1) : dividend;
  assign w_dvs_mag = divisor_b[7]  ? (~divisor_b + 8'd1) : divisor_b;

  // Partial remainder stays below |divisor| <= 128, so the difference always fits in 8 bits.
  assign w_trial   = {r_rem, r_dvd_sh[15]};
  assign w_ge      = (w_trial >= {1'b0, r_dvs_mag});
  assign w_diff    = w_trial[7:0] - r_dvs_mag;

  assign w_ovf     = r_sign_q ? (r_quo > 16'd128) : (r_quo > 16'd127);
  assign w_q_neg   = ~r_quo[7:0] + 8'd1;
  assign w_rem_neg = ~r_rem + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_dvd_sh    <= 16'd0;
      r_dvs_mag   <= 8'd0;
      r_rem       <= 8'd0;
      r_quo       <= 16'd0;
      r_cnt       <= 5'd0;
      r_sign_q    <= 1'b0;
      r_sign_r    <= 1'b0;
      r_zero      <= 1'b0;
      r_dvd_lo    <= 8'd0;
      quotient    <= 8'd0;
      remainder   <= 8'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dvd_sh  <= w_dvd_mag;
            r_dvs_mag <= w_dvs_mag;
            r_sign_q  <= dividend[15] ^ divisor_b[7];
            r_sign_r  <= dividend[15];
            r_zero    <= (divisor_b == 8'd0);
            r_dvd_lo  <= dividend[7:0];
            r_rem     <= 8'd0;
            r_quo     <= 16'd0;
            r_cnt     <= 5'd16;
            busy      <= 1'b1;
            r_state   <= S_CALC;
          end
        end
        S_CALC: begin
          r_dvd_sh <= {r_dvd_sh[14:0], 1'b0};
          r_rem    <= w_ge ? w_diff : w_trial[7:0];
          r_quo    <= {r_quo[14:0], w_ge};
          r_cnt    <= r_cnt - 5'd1;
          if (r_cnt == 5'd1) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (r_zero) begin
            quotient    <= r_sign_r ? 8'h80 : 8'h7F;
            remainder   <= r_dvd_lo;
            overflow    <= 1'b0;
            div_by_zero <= 1'b1;
          end else begin
            if (w_ovf) begin
              quotient <= r_sign_q ? 8'h80 : 8'h7F;
            end else begin
              quotient <= r_sign_q ? w_q_neg : r_quo[7:0];
            end
            remainder   <= r_sign_r ? w_rem_neg : r_rem;
            overflow    <= w_ovf;
            div_by_zero <= 1'b0;
          end
          busy    <= 1'b0;
          done    <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divide8_signed_seq.sv
// tb/tb_divide8_signed_seq.sv - self-checking bench for divide8_signed_seq
// Directed table, handshake/reset sequences, and random operands against an integer model.
module tb_divide8_signed_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor_b;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        busy;
  logic        done;
  logic        overflow;
  logic        div_by_zero;

  int n_checks;
  int n_errors;

  divide8_signed_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor_b   (divisor_b),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dvd;
    logic [7:0]  dvs;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        ovf;
    logic        dz;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division (truncating) plus saturation and flag rules.
  task automatic model(input logic [15:0] dvd, input logic [7:0] dvs,
                       output logic [7:0] q, output logic [7:0] r,
                       output logic ovf, output logic dz);
    logic signed [15:0] sa;
    logic signed [7:0]  sb;
    int a, b, qt, rt;
    sa = dvd;
    sb = dvs;
    a  = sa;
    b  = sb;
    if (b == 0) begin
      dz  = 1'b1;
      ovf = 1'b0;
      q   = (a >= 0) ? 8'h7F : 8'h80;
      r   = dvd[7:0];
    end else begin
      dz = 1'b0;
      qt = a / b;
      rt = a % b;
      if (qt > 127) begin
        q = 8'h7F; ovf = 1'b1;
      end else if (qt < -128) begin
        q = 8'h80; ovf = 1'b1;
      end else begin
        q = qt[7:0]; ovf = 1'b0;
      end
      r = rt[7:0];
    end
  endtask

  // Issue one operation, scramble operands after acceptance, wait for done (bounded).
  task automatic run_op(input logic [15:0] dvd, input logic [7:0] dvs, output int lat);
    @(posedge clk); #1;
    start     = 1'b1;
    dividend  = dvd;
    divisor_b = dvs;
    @(posedge clk); #1;
    start     = 1'b0;
    dividend  = 16'($urandom);
    divisor_b = 8'($urandom);
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  vec_t vecs[$];

  initial begin
    int lat;
    int ndone;
    int dtimes[$];
    logic [7:0] eq, er;
    logic eo, ez;
    logic [15:0] t;
    logic [15:0] rd;
    logic [7:0]  rs;

    n_checks  = 0;
    n_errors  = 0;
    start     = 1'b0;
    dividend  = 16'd0;
    divisor_b = 8'd0;
    rst_n     = 1'b1;

    vecs.push_back('{16'd100,  8'd7,   8'h0E, 8'h02, 1'b0, 1'b0});
    vecs.push_back('{16'hFF9C, 8'd7,   8'hF2, 8'hFE, 1'b0, 1'b0});
    vecs.push_back('{16'd100,  8'hF9,  8'hF2, 8'h02, 1'b0, 1'b0});
    vecs.push_back('{16'h4000, 8'h80,  8'h80, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{16'hC000, 8'h80,  8'h7F, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{16'h8000, 8'h80,  8'h7F, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{16'd1000, 8'd3,   8'h7F, 8'h01, 1'b1, 1'b0});
    vecs.push_back('{16'h8000, 8'hFF,  8'h7F, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{16'hFF80, 8'd1,   8'h80, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{16'h0080, 8'd1,   8'h7F, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{16'hFFFF, 8'd2,   8'h00, 8'hFF, 1'b0, 1'b0});
    vecs.push_back('{16'h1234, 8'd0,   8'h7F, 8'h34, 1'b0, 1'b1});
    vecs.push_back('{16'hFFFB, 8'd0,   8'h80, 8'hFB, 1'b0, 1'b1});

    #2 rst_n = 1'b0;
    #1;
    chk("rst_quotient",  {24'd0, quotient},  32'd0);
    chk("rst_remainder", {24'd0, remainder}, 32'd0);
    chk("rst_flags", {28'd0, busy, done, overflow, div_by_zero}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].dvd, vecs[i].dvs, lat);
      chk($sformatf("vec%0d_latency", i), lat, 32'd17);
      chk($sformatf("vec%0d_quotient", i), {24'd0, quotient}, {24'd0, vecs[i].q});
      chk($sformatf("vec%0d_remainder", i), {24'd0, remainder}, {24'd0, vecs[i].r});
      chk($sformatf("vec%0d_overflow", i), {31'd0, overflow}, {31'd0, vecs[i].ovf});
      chk($sformatf("vec%0d_div_by_zero", i), {31'd0, div_by_zero}, {31'd0, vecs[i].dz});
      chk($sformatf("vec%0d_busy_at_done", i), {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_done_one_cycle", i), {31'd0, done}, 32'd0);
      chk($sformatf("vec%0d_quotient_hold", i), {24'd0, quotient}, {24'd0, vecs[i].q});
    end

    // Extra start pulses mid-operation must be ignored.
    @(posedge clk); #1;
    start = 1'b1; dividend = 16'd100; divisor_b = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      start = (lat == 3 || lat == 10);
      dividend  = 16'hFFFB;
      divisor_b = 8'd3;
    end
    start = 1'b0;
    chk("hs_latency", lat, 32'd17);
    chk("hs_quotient", {24'd0, quotient}, 32'h0E);
    chk("hs_remainder", {24'd0, remainder}, 32'h02);
    @(posedge clk); #1;
    chk("hs_no_restart", {30'd0, busy, done}, 32'd0);

    // Start held high: one result every 18 cycles.
    start = 1'b1; dividend = 16'd1000; divisor_b = 8'hFD;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (done) begin
        dtimes.push_back(c);
        chk("b2b_quotient", {24'd0, quotient}, 32'h80);
        chk("b2b_remainder", {24'd0, remainder}, 32'h01);
        chk("b2b_overflow", {31'd0, overflow}, 32'd1);
      end
    end
    start = 1'b0;
    chk("b2b_done_count", dtimes.size(), 32'd3);
    if (dtimes.size() == 3) begin
      chk("b2b_first_done", dtimes[0], 32'd18);
      chk("b2b_period_1", dtimes[1] - dtimes[0], 32'd18);
      chk("b2b_period_2", dtimes[2] - dtimes[1], 32'd18);
    end
    repeat (20) @(posedge clk);
    #1;

    // Asynchronous reset in the middle of CALC.
    run_op(16'hFFFB, 8'd0, lat);
    chk("pre_reset_quotient", {24'd0, quotient}, 32'h80);
    @(posedge clk); #1;
    start = 1'b1; dividend = 16'd100; divisor_b = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_quotient",  {24'd0, quotient},  32'd0);
    chk("midrst_remainder", {24'd0, remainder}, 32'd0);
    chk("midrst_flags", {28'd0, busy, done, overflow, div_by_zero}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    chk("midrst_no_done", ndone, 32'd0);
    run_op(16'd1000, 8'd3, lat);
    chk("postrst_latency", lat, 32'd17);
    chk("postrst_quotient", {24'd0, quotient}, 32'h7F);
    chk("postrst_remainder", {24'd0, remainder}, 32'h01);

    // Random operands against the model.
    for (int n = 0; n < 2000; n++) begin
      t = 16'($urandom);
      if ($urandom_range(0, 1) == 1) rd = {{6{t[9]}}, t[9:0]};
      else rd = t;
      rs = 8'($urandom);
      if ($urandom_range(0, 15) == 0) rs = 8'd0;
      model(rd, rs, eq, er, eo, ez);
      run_op(rd, rs, lat);
      chk($sformatf("rnd%0d_latency(%h/%h)", n, rd, rs), lat, 32'd17);
      chk($sformatf("rnd%0d_quotient(%h/%h)", n, rd, rs), {24'd0, quotient}, {24'd0, eq});
      chk($sformatf("rnd%0d_remainder(%h/%h)", n, rd, rs), {24'd0, remainder}, {24'd0, er});
      chk($sformatf("rnd%0d_overflow(%h/%h)", n, rd, rs), {31'd0, overflow}, {31'd0, eo});
      chk($sformatf("rnd%0d_div_by_zero(%h/%h)", n, rd, rs), {31'd0, div_by_zero}, {31'd0, ez});
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
